// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared multiply/divide datapaths: latches operands,
// drives the step counter, short-circuits divide-by-zero and posts results.
module multdiv_sequencer #(
    parameter int MULT_CYCLES = 16,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] mult_result,
    input  logic        mult_overflow,
    input  logic [31:0] div_result,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic [5:0]  count,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [5:0] PARK   = 6'h3F;
    localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RUN_MULT,
        RUN_DIV,
        DIV_ZERO,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        busy_q, busy_d;
    logic        rdy_q, rdy_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (ctrl_MULT || ctrl_DIV) begin
            // A new request always wins, even over a completing op.
            opa_d = data_operandA;
            opb_d = data_operandB;
            if (ctrl_MULT) begin
                state_d = RUN_MULT;
                count_d = 6'd0;
            end else if (data_operandB == 32'd0) begin
                state_d = DIV_ZERO;
                count_d = PARK;
            end else begin
                state_d = RUN_DIV;
                count_d = 6'd0;
            end
        end else begin
            unique case (state_q)
                RUN_MULT: begin
                    if (count_q == MULT_N) begin
                        result_d = mult_result;
                        exc_d    = mult_overflow;
                        state_d  = DONE;
                        count_d  = PARK;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
                RUN_DIV: begin
                    if (count_q == DIV_N) begin
                        result_d = div_result;
                        exc_d    = 1'b0;
                        state_d  = DONE;
                        count_d  = PARK;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
                // Zero divisor: post the exception one edge after the request.
                DIV_ZERO: begin
                    result_d = 32'd0;
                    exc_d    = 1'b1;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN_MULT) || (state_d == RUN_DIV);
        rdy_d  = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            count_q  <= PARK;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign opA            = opa_q;
    assign opB            = opb_q;
    assign count          = count_q;
    assign busy           = busy_q;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: emulated datapaths, directed scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_multdiv_sequencer;

    localparam int MC = 16;
    localparam int DC = 32;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] mult_result;
    logic        mult_overflow;
    logic [31:0] div_result;
    logic [31:0] opA, opB, data_result;
    logic [5:0]  count;
    logic        busy, data_exception, data_resultRDY;

    int passed = 0;
    int total = 0;

    multdiv_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clock(clock), .resetN(resetN),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .mult_result(mult_result), .mult_overflow(mult_overflow),
        .div_result(div_result),
        .opA(opA), .opB(opB), .count(count), .busy(busy),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    // Datapath stand-ins: valid only at their terminal count, garbage otherwise.
    always_comb begin
        longint p;
        p = longint'($signed(opA)) * longint'($signed(opB));
        mult_result = 32'hDEADBEEF;
        mult_overflow = 1'b1;
        div_result = 32'hBAD00BAD;
        if (count == 6'(MC)) begin
            mult_result = p[31:0];
            mult_overflow = (p != longint'($signed(p[31:0])));
        end
        if (count == 6'(DC) && opB != 32'd0)
            div_result = 32'($signed(opA) / $signed(opB));
    end

    function automatic logic [32:0] model_mult(logic [31:0] a, logic [31:0] b);
        longint p;
        int lo;
        p = longint'(int'(a)) * longint'(int'(b));
        lo = int'(p[31:0]);
        return {p != longint'(lo), p[31:0]};
    endfunction

    function automatic logic [31:0] model_div(logic [31:0] a, logic [31:0] b);
        return 32'(int'(a) / int'(b));
    endfunction

    task automatic apply_reset;
        ctrl_MULT = 0;
        ctrl_DIV = 0;
        resetN = 0;
        repeat (2) @(negedge clock);
        resetN = 1;
        @(negedge clock);
    endtask

    // Call at a negedge; returns at the negedge where ready is seen.
    task automatic run_op(input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output bit seq_ok);
        ctrl_MULT = !is_div;
        ctrl_DIV = is_div;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 0;
        ctrl_DIV = 0;
        lat = -1;
        seq_ok = 1;
        for (int k = 0; k < 60; k++) begin
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (count !== 6'(k) || busy !== 1'b1 || opA !== a || opB !== b)
                seq_ok = 0;
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        total++; if (count !== 6'h3F) $display("FAIL rst_count: got %h want 3f", count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (data_resultRDY !== 1'b0) $display("FAIL rst_rdy: got %b want 0", data_resultRDY); else passed++;
        total++; if (data_result !== 32'd0) $display("FAIL rst_result: got %h want 0", data_result); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL rst_exc: got %b want 0", data_exception); else passed++;
        total++; if (opA !== 32'd0 || opB !== 32'd0) $display("FAIL rst_ops: got %h/%h want 0/0", opA, opB); else passed++;
    endtask

    task automatic test_mult;
        int lat; bit ok;
        run_op(0, 32'd7, 32'hFFFFFFFD, lat, ok);
        total++; if (lat !== MC + 1) $display("FAIL mult_lat: got %0d want %0d", lat, MC + 1); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL mult_seq: got %b want 1", ok); else passed++;
        total++; if (data_result !== 32'hFFFFFFEB) $display("FAIL mult_res: got %h want ffffffeb", data_result); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL mult_exc: got %b want 0", data_exception); else passed++;
        total++; if (busy !== 1'b0 || count !== 6'h3F) $display("FAIL mult_done: busy %b count %h want 0/3f", busy, count); else passed++;
        @(negedge clock);
        total++; if (data_resultRDY !== 1'b0) $display("FAIL mult_pulse: got %b want 0", data_resultRDY); else passed++;
    endtask

    task automatic test_div;
        int lat; bit ok;
        run_op(1, 32'hFFFFFF9C, 32'd7, lat, ok);
        total++; if (lat !== DC + 1) $display("FAIL div_lat: got %0d want %0d", lat, DC + 1); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL div_seq_stable: got %b want 1", ok); else passed++;
        total++; if (data_result !== 32'hFFFFFFF2) $display("FAIL div_res: got %h want fffffff2", data_result); else passed++;
        total++; if (data_exception !== 1'b0) $display("FAIL div_exc: got %b want 0", data_exception); else passed++;
    endtask

    task automatic test_div_zero;
        ctrl_DIV = 1;
        data_operandA = 32'd5;
        data_operandB = 32'd0;
        @(negedge clock);
        ctrl_DIV = 0;
        total++; if (data_resultRDY !== 1'b0 || count !== 6'h3F) $display("FAIL dz_e0: rdy %b count %h want 0/3f", data_resultRDY, count); else passed++;
        @(negedge clock);
        total++; if (data_resultRDY !== 1'b1) $display("FAIL dz_rdy: got %b want 1", data_resultRDY); else passed++;
        total++; if (data_result !== 32'd0 || data_exception !== 1'b1) $display("FAIL dz_res: got %h/%b want 0/1", data_result, data_exception); else passed++;
        total++; if (count !== 6'h3F) $display("FAIL dz_count: got %h want 3f", count); else passed++;
        @(negedge clock);
        total++; if (data_resultRDY !== 1'b0) $display("FAIL dz_pulse: got %b want 0", data_resultRDY); else passed++;
    endtask

    task automatic test_overflow;
        int lat; bit ok;
        run_op(0, 32'h40000000, 32'd4, lat, ok);
        total++; if (lat !== MC + 1 || data_exception !== 1'b1) $display("FAIL ovf_exc: lat %0d exc %b want %0d/1", lat, data_exception, MC + 1); else passed++;
        total++; if (data_result !== 32'd0) $display("FAIL ovf_res: got %h want 0", data_result); else passed++;
        run_op(1, 32'd9, 32'd3, lat, ok);
        total++; if (data_result !== 32'd3 || data_exception !== 1'b0) $display("FAIL ovf_next_div: got %h/%b want 3/0", data_result, data_exception); else passed++;
    endtask

    task automatic test_both_requests;
        int lat;
        ctrl_MULT = 1;
        ctrl_DIV = 1;
        data_operandA = 32'd11;
        data_operandB = 32'd13;
        @(negedge clock);
        ctrl_MULT = 0;
        ctrl_DIV = 0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (data_resultRDY) begin lat = k; break; end
            @(negedge clock);
        end
        total++; if (lat !== MC + 1 || data_result !== 32'd143) $display("FAIL both_mult_wins: lat %0d res %0d want %0d/143", lat, data_result, MC + 1); else passed++;
    endtask

    task automatic test_abort;
        int lat, pulses; bit ok;
        ctrl_DIV = 1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(negedge clock);
        ctrl_DIV = 0;
        for (int k = 0; k < 20 && count !== 6'd10; k++) @(negedge clock);
        total++; if (count !== 6'd10) $display("FAIL abort_reach: got %h want 0a", count); else passed++;
        run_op(0, 32'd6, 32'd6, lat, ok);
        total++; if (lat !== MC + 1) $display("FAIL abort_lat: got %0d want %0d", lat, MC + 1); else passed++;
        total++; if (data_result !== 32'd36) $display("FAIL abort_res: got %0d want 36", data_result); else passed++;
        pulses = 0;
        repeat (40) begin @(negedge clock); if (data_resultRDY) pulses++; end
        total++; if (pulses !== 0) $display("FAIL abort_extra_rdy: got %0d want 0", pulses); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat; bit ok;
        run_op(0, 32'd3, 32'd5, lat, ok);
        total++; if (data_result !== 32'd15) $display("FAIL b2b_first: got %0d want 15", data_result); else passed++;
        run_op(1, 32'd50, 32'd5, lat, ok);
        total++; if (lat !== DC + 1 || ok !== 1'b1) $display("FAIL b2b_second_lat: got %0d/%b want %0d/1", lat, ok, DC + 1); else passed++;
        total++; if (data_result !== 32'd10) $display("FAIL b2b_second_res: got %0d want 10", data_result); else passed++;
    endtask

    task automatic test_same_edge;
        int lat; bit ok;
        logic [31:0] prev;
        prev = data_result;
        ctrl_MULT = 1;
        data_operandA = 32'd1234;
        data_operandB = 32'd2;
        @(negedge clock);
        ctrl_MULT = 0;
        for (int k = 0; k < 20 && count !== 6'(MC); k++) @(negedge clock);
        total++; if (data_result !== prev) $display("FAIL hold_result: got %h want %h", data_result, prev); else passed++;
        run_op(1, 32'd77, 32'd7, lat, ok);
        total++; if (lat !== DC + 1) $display("FAIL same_edge_lat: got %0d want %0d", lat, DC + 1); else passed++;
        total++; if (data_result !== 32'd11) $display("FAIL same_edge_res: got %0d want 11", data_result); else passed++;
    endtask

    task automatic test_random;
        int lat; bit ok, is_div;
        logic [31:0] a, b, exp_r;
        logic exp_e;
        logic [32:0] m;
        for (int i = 0; i < 16; i++) begin
            is_div = bit'($urandom_range(1));
            a = $urandom >> $urandom_range(31);
            if ($urandom_range(1) == 1) a = -a;
            b = $urandom >> $urandom_range(31);
            if (b == 32'd0) b = 32'd1;
            if ($urandom_range(1) == 1) b = -b;
            if (is_div) begin
                exp_r = model_div(a, b);
                exp_e = 1'b0;
            end else begin
                m = model_mult(a, b);
                exp_r = m[31:0];
                exp_e = m[32];
            end
            run_op(is_div, a, b, lat, ok);
            total++; if (lat !== (is_div ? DC + 1 : MC + 1) || ok !== 1'b1) $display("FAIL rnd_timing[%0d]: lat %0d seq %b div %b", i, lat, ok, is_div); else passed++;
            total++; if (data_result !== exp_r || data_exception !== exp_e) $display("FAIL rnd_res[%0d]: got %h/%b want %h/%b", i, data_result, data_exception, exp_r, exp_e); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        ctrl_DIV = 1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_DIV = 0;
        for (int k = 0; k < 30 && count !== 6'd20; k++) @(negedge clock);
        #2;
        resetN = 0;
        #1;
        total++; if (busy !== 1'b0 || count !== 6'h3F) $display("FAIL rstmid_async: busy %b count %h want 0/3f", busy, count); else passed++;
        total++; if (opA !== 32'd0 || data_result !== 32'd0) $display("FAIL rstmid_clear: opA %h res %h want 0/0", opA, data_result); else passed++;
        @(negedge clock);
        resetN = 1;
        pulses = 0;
        repeat (40) begin @(negedge clock); if (data_resultRDY) pulses++; end
        total++; if (pulses !== 0) $display("FAIL rstmid_rdy: got %0d want 0", pulses); else passed++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_overflow();
        test_both_requests();
        test_abort();
        test_back_to_back();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
